// File: rtl/target_scheduler_if.sv
// Handshake bundle between the random-cell source/player input and the target scheduler.
// master drives samples and player hits; slave returns the lit target and the score state.
interface target_scheduler_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic [3:0]          rand_val;
  logic                sample_en;
  logic                hit_strobe;
  logic [3:0]          hit_cell;
  logic                target_valid;
  logic [3:0]          target_cell;
  logic [7:0]          score;
  logic [7:0]          misses;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                overflow;

  modport master (
    output rand_val, sample_en, hit_strobe, hit_cell,
    input  target_valid, target_cell, score, misses, fifo_level, overflow
  );

  modport slave (
    input  rand_val, sample_en, hit_strobe, hit_cell,
    output target_valid, target_cell, score, misses, fifo_level, overflow
  );
endinterface

// File: rtl/target_scheduler.sv
// Queues random 4x4 grid cells and shows them one at a time for a hold window, scoring hits/misses.
// Optional macro DUP_FILTER_EN: drop a sample equal to the last value written into the FIFO.
module target_scheduler #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 5000000
) (
  input logic             CLK,
  input logic             reset,
  target_scheduler_if.slave bus
);
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
  localparam int unsigned T_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                state;
  logic [TIMER_W-1:0]    timer;
  logic [3:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  target_valid;
  logic [3:0]            target_cell;
  logic [7:0]            score;
  logic [7:0]            misses;
  logic                  overflow;

  logic empty_c;
  logic full_c;
  logic dup_c;
  logic push_req_c;
  logic push_c;
  logic pop_c;
  logic hit_c;

  assign empty_c    = (level == '0);
  assign full_c     = (level == LVL_W'(DEPTH));
  assign push_req_c = bus.sample_en && !dup_c;
  assign push_c     = push_req_c && !full_c;
  assign pop_c      = (state == IDLE) && !empty_c;
  assign hit_c      = bus.hit_strobe && (bus.hit_cell == target_cell);

`ifdef DUP_FILTER_EN
  logic [3:0] last_wr;
  logic       last_wr_ok;

  // last_wr_ok keeps the cleared register from matching a genuine first sample of 0
  always_ff @(posedge CLK) begin
    if (reset) begin
      last_wr    <= 4'd0;
      last_wr_ok <= 1'b0;
    end else if (push_c) begin
      last_wr    <= bus.rand_val;
      last_wr_ok <= 1'b1;
    end
  end

  assign dup_c = last_wr_ok && (bus.rand_val == last_wr);
`else
  assign dup_c = 1'b0;
`endif

  // storage needs no reset; the level counter decides what is valid
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.rand_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      target_valid <= 1'b0;
      target_cell  <= 4'd0;
      score        <= 8'd0;
      misses       <= 8'd0;
      overflow     <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (push_req_c && full_c) begin
        overflow <= 1'b1;
      end
      level <= level + LVL_W'(push_c) - LVL_W'(pop_c);

      case (state)
        IDLE: begin
          if (pop_c) begin
            target_cell  <= mem[rd_ptr];
            target_valid <= 1'b1;
            timer        <= TIMER_W'(HOLD_CYCLES - 1);
            state        <= SHOW;
          end
        end
        SHOW: begin
          // a correct hit wins over the timeout on the final cycle
          if (hit_c) begin
            if (score != 8'hFF) score <= score + 8'd1;
            target_valid <= 1'b0;
            timer        <= TIMER_W'(GAP_CYCLES - 1);
            state        <= GAP;
          end else if (timer == '0) begin
            if (misses != 8'hFF) misses <= misses + 8'd1;
            target_valid <= 1'b0;
            timer        <= TIMER_W'(GAP_CYCLES - 1);
            state        <= GAP;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        GAP: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.target_valid = target_valid;
  assign bus.target_cell  = target_cell;
  assign bus.score        = score;
  assign bus.misses       = misses;
  assign bus.fifo_level   = level;
  assign bus.overflow     = overflow;
endmodule

// File: tb/tb_target_scheduler.sv
// Bench for target_scheduler: directed scenarios plus random traffic against a queue-based model.
// Build with DUP_FILTER_EN defined to exercise the duplicate filter.
module tb_target_scheduler;
  localparam int unsigned DEPTH_LOG2 = 3;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned HOLD       = 16;
  localparam int unsigned GAPC       = 3;
`ifdef DUP_FILTER_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  target_scheduler_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  target_scheduler #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // reference model: a queue of pending cells plus the phase of the current target
  int         q[$];
  bit         m_valid;
  logic [3:0] m_cell;
  int         m_score;
  int         m_miss;
  bit         m_over;
  int         phase;    // 0 waiting, 1 lit, 2 blank gap
  int         rem;      // cycles left in the current lit/gap window
  logic [3:0] last_wr;
  bit         last_ok;

  task automatic model_update();
    bit do_pop;
    bit full;
    bit req;
    int head;
    if (reset) begin
      q.delete();
      m_valid = 0; m_cell = 0; m_score = 0; m_miss = 0; m_over = 0;
      phase = 0; rem = 0; last_wr = 0; last_ok = 0;
      return;
    end
    do_pop = (phase == 0) && (q.size() > 0);
    full   = (q.size() == DEPTH);
    head   = 0;
    if (do_pop) head = q.pop_front();
    req = bus.sample_en && !(DUP && last_ok && bus.rand_val == last_wr);
    if (req) begin
      if (full) m_over = 1;
      else begin
        q.push_back(int'(bus.rand_val));
        last_wr = bus.rand_val;
        last_ok = 1;
      end
    end
    case (phase)
      0: if (do_pop) begin
        m_cell = 4'(head); m_valid = 1; phase = 1; rem = HOLD;
      end
      1: begin
        if (bus.hit_strobe && bus.hit_cell == m_cell) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_valid = 0; phase = 2; rem = GAPC;
        end else if (rem == 1) begin
          m_miss = (m_miss < 255) ? m_miss + 1 : 255;
          m_valid = 0; phase = 2; rem = GAPC;
        end else rem--;
      end
      default: if (rem == 1) phase = 0; else rem--;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("target_valid", 32'(bus.target_valid), 32'(m_valid));
    check("target_cell",  32'(bus.target_cell),  32'(m_cell));
    check("score",        32'(bus.score),        32'(m_score));
    check("misses",       32'(bus.misses),       32'(m_miss));
    check("fifo_level",   32'(bus.fifo_level),   32'(q.size()));
    check("overflow",     32'(bus.overflow),     32'(m_over));
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [3:0] v);
    bus.sample_en = 1'b1;
    bus.rand_val  = v;
    step();
    bus.sample_en = 1'b0;
  endtask

  task automatic hit(input logic [3:0] c);
    bus.hit_strobe = 1'b1;
    bus.hit_cell   = c;
    step();
    bus.hit_strobe = 1'b0;
  endtask

  task automatic wait_lit(input string tag);
    int n = 0;
    while (bus.target_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(bus.target_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.rand_val   = 4'd0;
    bus.sample_en  = 1'b0;
    bus.hit_strobe = 1'b0;
    bus.hit_cell   = 4'd0;
    run(2);
    reset = 1'b0;
    check("reset_valid", 32'(bus.target_valid), 32'd0);
    check("reset_level", 32'(bus.fifo_level), 32'd0);

    // 1: push into empty FIFO, lit two edges later
    push(4'd5);
    check("t1_level_after_push", 32'(bus.fifo_level), 32'd1);
    check("t1_not_yet_lit", 32'(bus.target_valid), 32'd0);
    step();
    check("t1_lit", 32'(bus.target_valid), 32'd1);
    check("t1_cell", 32'(bus.target_cell), 32'd5);
    check("t1_level_after_pop", 32'(bus.fifo_level), 32'd0);

    // 2: correct hit then gap
    hit(4'd5);
    check("t2_score", 32'(bus.score), 32'd1);
    check("t2_dark", 32'(bus.target_valid), 32'd0);
    check("t2_cell_held", 32'(bus.target_cell), 32'd5);
    run(GAPC + 2);

    // 3: wrong cell ignored, then timeout
    push(4'd6);
    wait_lit("t3_lit");
    hit(4'd3);
    check("t3_wrong_hit_score", 32'(bus.score), 32'd1);
    run(HOLD - 2);
    check("t3_still_lit", 32'(bus.misses), 32'd0);
    step();
    check("t3_miss", 32'(bus.misses), 32'd1);
    check("t3_dark", 32'(bus.target_valid), 32'd0);
    run(GAPC + 2);

    // 4: overfill while a target is lit, then drain in order
    push(4'd10);
    wait_lit("t4_lit");
    for (int i = 0; i < 9; i++) push(4'(i));
    check("t4_level_full", 32'(bus.fifo_level), 32'd8);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    hit(4'd10);
    for (int k = 0; k < 8; k++) begin
      wait_lit("t4_lit_k");
      check("t4_order", 32'(bus.target_cell), 32'(k));
      hit(bus.target_cell);
    end
    run(GAPC + 2);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      reset          = (($urandom % 150) == 0);
      bus.sample_en  = (($urandom % 4) == 0);
      bus.rand_val   = 4'($urandom);
      bus.hit_strobe = (($urandom % 3) == 0);
      bus.hit_cell   = ($urandom % 2) ? m_cell : 4'($urandom);
      step();
    end
    reset = 1'b0; bus.sample_en = 1'b0; bus.hit_strobe = 1'b0;

    // 5: reset mid-show with entries queued
    do_reset();
    push(4'd1);
    wait_lit("t5_lit");
    push(4'd2); push(4'd3); push(4'd4);
    check("t5_level_before", 32'(bus.fifo_level), 32'd3);
    do_reset();
    check("t5_valid", 32'(bus.target_valid), 32'd0);
    check("t5_cell", 32'(bus.target_cell), 32'd0);
    check("t5_score", 32'(bus.score), 32'd0);
    check("t5_misses", 32'(bus.misses), 32'd0);
    check("t5_level", 32'(bus.fifo_level), 32'd0);
    check("t5_overflow", 32'(bus.overflow), 32'd0);

    // score saturation
    for (int i = 0; i < 258; i++) begin
      push(4'(i));
      wait_lit("sat_hit_lit");
      hit(bus.target_cell);
    end
    check("score_sat", 32'(bus.score), 32'd255);

    // miss saturation
    for (int i = 0; i < 257; i++) begin
      push(4'(i));
      wait_lit("sat_miss_lit");
      run(HOLD);
    end
    check("miss_sat", 32'(bus.misses), 32'd255);
    check("score_held", 32'(bus.score), 32'd255);
    run(GAPC + 2);

    // 6: duplicate filter behaviour
    do_reset();
    push(4'd0);
    wait_lit("t6_lit");
    push(4'd7); push(4'd7); push(4'd2);
    check("t6_level", 32'(bus.fifo_level), DUP ? 32'd2 : 32'd3);
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
